// File: rtl/shot_clock_ctrl.sv
// Shot-clock front end: 2-flop sync + debounce of restart/pause buttons, driving `but` pulse and `stop` level.
// Latency: raw edge to output is DEBOUNCE_CYCLES+3 clk edges; no backpressure (outputs are free-running registers).

module shot_clock_sync #(
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic s
);

  logic [1:0] sync_ff;

  // Flops reset to the released level so no false press is seen on reset exit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_ff <= {2{ACTIVE_LOW}};
    end else begin
      sync_ff <= {sync_ff[0], raw};
    end
  end

  assign s = sync_ff[1] ^ ACTIVE_LOW;

endmodule

module shot_clock_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic s,
  output logic press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  // Entry into a WAIT state is the first stable cycle, so the count ends at D-2.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 2);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      press <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (s) begin
            state <= PRESS_WAIT;
          end
        end
        PRESS_WAIT: begin
          if (!s) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= HELD;
            cnt   <= '0;
            press <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        HELD: begin
          cnt <= '0;
          if (!s) begin
            state <= RELEASE_WAIT;
          end
        end
        RELEASE_WAIT: begin
          if (s) begin
            state <= HELD;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

module shot_clock_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter bit BTN_ACTIVE_LOW  = 1'b0,
  parameter bit STOP_AT_RESET   = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_restart,
  input  logic btn_pause,
  output logic but,
  output logic stop,
  output logic pause_ack
);

  logic s_restart;
  logic s_pause;
  logic restart_evt;
  logic pause_evt;

  shot_clock_sync #(.ACTIVE_LOW(BTN_ACTIVE_LOW)) u_sync_restart (
    .clk (clk),
    .rst (rst),
    .raw (btn_restart),
    .s   (s_restart)
  );

  shot_clock_sync #(.ACTIVE_LOW(BTN_ACTIVE_LOW)) u_sync_pause (
    .clk (clk),
    .rst (rst),
    .raw (btn_pause),
    .s   (s_pause)
  );

  shot_clock_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_restart (
    .clk   (clk),
    .rst   (rst),
    .s     (s_restart),
    .press (restart_evt)
  );

  shot_clock_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_pause (
    .clk   (clk),
    .rst   (rst),
    .s     (s_pause),
    .press (pause_evt)
  );

  // `but` feeds an async preset downstream, so all outputs come straight from flops.
  // Restart dominates a coincident pause; the ack still pulses but the toggle is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      but       <= 1'b0;
      pause_ack <= 1'b0;
      stop      <= STOP_AT_RESET;
    end else begin
      but       <= restart_evt;
      pause_ack <= pause_evt;
      if (restart_evt) begin
        stop <= 1'b0;
      end else if (pause_evt) begin
        stop <= ~stop;
      end
    end
  end

endmodule

// File: tb/tb_shot_clock_ctrl.sv
// Scoreboard bench for shot_clock_ctrl: active-high and active-low instances share one expected event stream.
module tb_shot_clock_ctrl;

  localparam int D = 4;
  localparam int LAT = D + 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_restart = 1'b0;
  logic btn_pause = 1'b0;
  logic btn_restart_n;
  logic btn_pause_n;
  logic but_h, stop_h, ack_h;
  logic but_l, stop_l, ack_l;

  assign btn_restart_n = ~btn_restart;
  assign btn_pause_n   = ~btn_pause;

  always #5 clk = ~clk;

  shot_clock_ctrl #(.DEBOUNCE_CYCLES(D), .BTN_ACTIVE_LOW(1'b0), .STOP_AT_RESET(1'b1)) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_restart (btn_restart),
    .btn_pause   (btn_pause),
    .but         (but_h),
    .stop        (stop_h),
    .pause_ack   (ack_h)
  );

  shot_clock_ctrl #(.DEBOUNCE_CYCLES(D), .BTN_ACTIVE_LOW(1'b1), .STOP_AT_RESET(1'b1)) dut_al (
    .clk         (clk),
    .rst         (rst),
    .btn_restart (btn_restart_n),
    .btn_pause   (btn_pause_n),
    .but         (but_l),
    .stop        (stop_l),
    .pause_ack   (ack_l)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    bit but;
    bit ack;
    bit stop;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push(input int c, input bit b, input bit a, input bit s);
    exp_t e;
    e.cyc  = c;
    e.but  = b;
    e.ack  = a;
    e.stop = s;
    exp_q.push_back(e);
  endtask

  task automatic chk_idle_outputs(input string tag, input bit exp_stop);
    chk({tag, "_but_h"}, but_h, 0);
    chk({tag, "_ack_h"}, ack_h, 0);
    chk({tag, "_stop_h"}, stop_h, exp_stop);
    chk({tag, "_but_l"}, but_l, 0);
    chk({tag, "_ack_l"}, ack_l, 0);
    chk({tag, "_stop_l"}, stop_l, exp_stop);
  endtask

  // Monitor: any output pulse on either instance consumes one expected event.
  always @(negedge clk) begin
    if (!rst && (but_h || ack_h || but_l || ack_l)) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event: cycle %0d but_h=%0b ack_h=%0b but_l=%0b ack_l=%0b, expected none",
                 cyc, but_h, ack_h, but_l, ack_l);
      end else begin
        mon_e = exp_q.pop_front();
        chk("event_cycle", cyc, mon_e.cyc);
        chk("but_h", but_h, mon_e.but);
        chk("ack_h", ack_h, mon_e.ack);
        chk("stop_h", stop_h, mon_e.stop);
        chk("but_l", but_l, mon_e.but);
        chk("ack_l", ack_l, mon_e.ack);
        chk("stop_l", stop_l, mon_e.stop);
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    // Reset with buttons idle
    wait_cyc(3);
    chk_idle_outputs("in_reset", 1'b1);
    rst = 1'b0;
    wait_cyc(10);
    chk_idle_outputs("post_reset_idle", 1'b1);

    // Clean restart press, held well past the debounce window
    push(cyc + LAT, 1'b1, 1'b0, 1'b0);
    btn_restart = 1'b1;
    wait_cyc(20);
    btn_restart = 1'b0;
    wait_cyc(10);
    chk_idle_outputs("after_restart", 1'b0);

    // Two clean pause presses
    push(cyc + LAT, 1'b0, 1'b1, 1'b1);
    btn_pause = 1'b1;
    wait_cyc(12);
    btn_pause = 1'b0;
    wait_cyc(10);
    chk_idle_outputs("after_pause1", 1'b1);
    push(cyc + LAT, 1'b0, 1'b1, 1'b0);
    btn_pause = 1'b1;
    wait_cyc(12);
    btn_pause = 1'b0;
    wait_cyc(10);
    chk_idle_outputs("after_pause2", 1'b0);

    // Bounce 1,0,1,0 with 2-cycle phases, then held
    for (int i = 0; i < 2; i++) begin
      btn_pause = 1'b1;
      wait_cyc(2);
      btn_pause = 1'b0;
      wait_cyc(2);
    end
    push(cyc + LAT, 1'b0, 1'b1, 1'b1);
    btn_pause = 1'b1;
    wait_cyc(12);
    btn_pause = 1'b0;
    wait_cyc(10);
    chk_idle_outputs("after_bounce", 1'b1);

    // Simultaneous restart and pause with stop=1: restart wins
    push(cyc + LAT, 1'b1, 1'b1, 1'b0);
    btn_restart = 1'b1;
    btn_pause   = 1'b1;
    wait_cyc(12);
    btn_restart = 1'b0;
    btn_pause   = 1'b0;
    wait_cyc(10);
    chk_idle_outputs("after_simul", 1'b0);

    // Reset while restart debounce counter sits at 2
    btn_restart = 1'b1;
    wait_cyc(5);
    rst = 1'b1;
    wait_cyc(1);
    chk_idle_outputs("mid_debounce_reset", 1'b1);
    wait_cyc(1);
    rst = 1'b0;
    push(cyc + LAT, 1'b1, 1'b0, 1'b0);
    wait_cyc(12);
    btn_restart = 1'b0;
    wait_cyc(10);
    chk_idle_outputs("after_reset_restart", 1'b0);

    chk("events_outstanding", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: cycle %0d, expected completion", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
